// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam int DEF_LAT     = 4;
  localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick. When both requesters ask, the one
// that was not granted last wins; a lone requester always wins.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  // One-hot grant; zero when nobody is asking.
  always_comb begin
    grant = 2'b00;
    if (valid[1] && (!valid[0] || !last)) begin
      grant = 2'b10;
    end else if (valid[0]) begin
      grant = 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin front end sharing one memory port between a fetch
// requester (0) and a load/store requester (1). Addresses are range checked
// before the memory is strobed; memEnable is held at least LAT cycles.
// Build option: define MEM_ARB_TIMEOUT_EN to add a WAIT watchdog that ends a
// stalled access with done+err after TIMEOUT cycles of memEnable.
//
// state | meaning
// IDLE  | no access in flight; grant the round-robin winner and latch its request
// ISSUE | range check; drive operands and op one cycle ahead of memEnable
// WAIT  | memEnable high; wait for LAT cycles and memDone (or watchdog)
// RESP  | pulse done (and err) to the owner, move the round-robin pointer
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int SIZE      = 32,
  parameter int MAX_RANGE = 10,
  parameter int LAT       = DEF_LAT,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_write,
  input  logic [4*SIZE-1:0] req_addr1,
  input  logic [4*SIZE-1:0] req_addr2,
  input  logic [4*SIZE-1:0] req_wdata,
  output logic [1:0]        req_grant,
  output logic [1:0]        req_done,
  output logic [1:0]        req_err,
  output logic [2*SIZE-1:0] rdata1,
  output logic [2*SIZE-1:0] rdata2,
  output logic              memoryControl,
  output logic [2*SIZE-1:0] data1,
  output logic [2*SIZE-1:0] data2,
  output logic              memEnable,
  input  logic              memDone,
  input  logic [2*SIZE-1:0] dataOutput1,
  input  logic [2*SIZE-1:0] dataOutput2
);

  localparam int W  = 2 * SIZE;
  localparam int CW = $clog2(LAT + TIMEOUT + 2);
  localparam logic [W-1:0]  ADDR_LIM = W'(MAX_RANGE);
  localparam logic [CW-1:0] LAT_LOAD = CW'(LAT - 1);
`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_LOAD = CW'(TIMEOUT - 1);
  logic [CW-1:0] tmo_cnt;
`endif

  arb_state_t    state;
  logic          last;
  logic          owner;
  logic          op;
  logic          fail;
  logic [W-1:0]  op_a1, op_a2, op_wd;
  logic [CW-1:0] lat_cnt;

  logic [1:0]    grant;
  logic          sel;
  logic          sel_op;
  logic [W-1:0]  sel_a1, sel_a2, sel_wd;
  logic          range_ok;

  rr_arbiter2 u_rr (
    .valid (req_valid),
    .last  (last),
    .grant (grant)
  );

  // Route the winning requester's slice to the latch stage and range check
  // the latched request (addr1 only matters for reads).
  always_comb begin
    sel      = grant[1];
    sel_op   = sel ? req_write[1] : req_write[0];
    sel_a1   = sel ? req_addr1[2*W-1:W] : req_addr1[W-1:0];
    sel_a2   = sel ? req_addr2[2*W-1:W] : req_addr2[W-1:0];
    sel_wd   = sel ? req_wdata[2*W-1:W] : req_wdata[W-1:0];
    range_ok = (op_a2 < ADDR_LIM) && ((op == MEM_WRITE) || (op_a1 < ADDR_LIM));
  end

  // Access sequencer; all outputs are registered. Counters run down and the
  // access may finish only once the latency counter has reached zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      last          <= 1'b1;
      owner         <= 1'b0;
      op            <= MEM_READ;
      fail          <= 1'b0;
      op_a1         <= '0;
      op_a2         <= '0;
      op_wd         <= '0;
      lat_cnt       <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
      req_grant     <= 2'b00;
      req_done      <= 2'b00;
      req_err       <= 2'b00;
      rdata1        <= '0;
      rdata2        <= '0;
      memoryControl <= MEM_READ;
      data1         <= '0;
      data2         <= '0;
      memEnable     <= 1'b0;
    end else begin
      req_grant <= 2'b00;
      req_done  <= 2'b00;
      req_err   <= 2'b00;
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            req_grant <= grant;
            owner     <= sel;
            op        <= sel_op;
            op_a1     <= sel_a1;
            op_a2     <= sel_a2;
            op_wd     <= sel_wd;
            fail      <= 1'b0;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (range_ok) begin
            memoryControl <= op;
            data1         <= (op == MEM_WRITE) ? op_wd : op_a1;
            data2         <= op_a2;
            state         <= ST_WAIT;
          end else begin
            fail  <= 1'b1;
            state <= ST_RESP;
          end
        end
        ST_WAIT: begin
          if (!memEnable) begin
            memEnable <= 1'b1;
            lat_cnt   <= LAT_LOAD;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_cnt   <= TMO_LOAD;
`endif
          end else if ((lat_cnt == '0) && memDone) begin
            memEnable <= 1'b0;
            if (op == MEM_READ) begin
              rdata1 <= dataOutput1;
              rdata2 <= dataOutput2;
            end
            state <= ST_RESP;
`ifdef MEM_ARB_TIMEOUT_EN
          end else if (tmo_cnt == '0) begin
            memEnable <= 1'b0;
            fail      <= 1'b1;
            state     <= ST_RESP;
`endif
          end else begin
            if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_cnt <= tmo_cnt - 1'b1;
`endif
          end
        end
        ST_RESP: begin
          req_done[owner] <= 1'b1;
          req_err[owner]  <= fail;
          last            <= owner;
          state           <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
